// File: rtl/pico_l1_responder.sv
// pico_l1_responder: 32-line direct-mapped, write-back, write-allocate L1 behind the picorv32 mem_* port.
// Define PICO_L1_STATS_EN to build the saturating hit/miss counters; otherwise both read 0.
module pico_l1_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [8:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bmem_req,
  output logic        bmem_we,
  output logic [8:0]  bmem_addr,
  output logic [31:0] bmem_wdata,
  input  logic        bmem_ack,
  input  logic [31:0] bmem_rdata,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  // state  | meaning
  // IDLE   | waiting for a core request
  // LOOKUP | tag compare on the latched request; hits resolve here
  // WB     | writing the dirty victim back to main memory
  // FILL   | fetching the requested word from main memory
  // RESP   | mem_ready pulse to the core
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;
  state_t state, state_nxt;

  logic [6:0]  req_word;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;

  logic [31:0] data_mem [32];
  logic [1:0]  tag_mem  [32];
  logic [31:0] line_valid;
  logic [31:0] line_dirty;

  logic [4:0]  idx;
  logic [1:0]  req_tag;
  logic        req_write;
  logic [31:0] line_data;
  logic [1:0]  line_tag;
  logic        hit;

  logic        accept;
  logic        ready_nxt;
  logic [31:0] rdata_nxt;
  logic        breq_nxt;
  logic        bwe_nxt;
  logic [8:0]  baddr_nxt;
  logic [31:0] bwdata_nxt;
  logic        line_we;
  logic [31:0] line_wdata;
  logic        set_valid;
  logic        set_dirty;
  logic        clr_dirty;
  logic        hit_evt;
  logic        miss_evt;
  logic [31:0] fill_word;

  // Byte offset and the fetch flag carry no meaning for a word-wide line.
  logic unused_inputs;
  assign unused_inputs = ^{mem_instr, mem_addr[1:0]};

  assign idx       = req_word[4:0];
  assign req_tag   = req_word[6:5];
  assign req_write = |req_wstrb;
  assign line_data = data_mem[idx];
  assign line_tag  = tag_mem[idx];
  assign hit       = line_valid[idx] && (line_tag == req_tag);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] r;
    r = old_word;
    for (int k = 0; k < 4; k++)
      if (wstrb[k]) r[8*k +: 8] = wdata[8*k +: 8];
    return r;
  endfunction

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    ready_nxt  = 1'b0;
    rdata_nxt  = mem_rdata;
    breq_nxt   = bmem_req;
    bwe_nxt    = bmem_we;
    baddr_nxt  = bmem_addr;
    bwdata_nxt = bmem_wdata;
    line_we    = 1'b0;
    line_wdata = line_data;
    set_valid  = 1'b0;
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;
    hit_evt    = 1'b0;
    miss_evt   = 1'b0;
    fill_word  = req_write ? merge_bytes(bmem_rdata, req_wdata, req_wstrb) : bmem_rdata;
    case (state)
      IDLE: begin
        if (mem_valid && !mem_ready) begin
          accept    = 1'b1;
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          hit_evt   = 1'b1;
          ready_nxt = 1'b1;
          state_nxt = RESP;
          if (req_write) begin
            line_wdata = merge_bytes(line_data, req_wdata, req_wstrb);
            line_we    = 1'b1;
            set_dirty  = 1'b1;
            rdata_nxt  = line_wdata;
          end else begin
            rdata_nxt  = line_data;
          end
        end else begin
          miss_evt = 1'b1;
          breq_nxt = 1'b1;
          if (line_valid[idx] && line_dirty[idx]) begin
            bwe_nxt    = 1'b1;
            baddr_nxt  = {line_tag, idx, 2'b00};
            bwdata_nxt = line_data;
            state_nxt  = WB;
          end else begin
            bwe_nxt    = 1'b0;
            baddr_nxt  = {req_tag, idx, 2'b00};
            state_nxt  = FILL;
          end
        end
      end
      WB: begin
        if (bmem_ack) begin
          clr_dirty = 1'b1;
          breq_nxt  = 1'b0;
          bwe_nxt   = 1'b0;
          state_nxt = FILL;
        end
      end
      FILL: begin
        // After a writeback the request is re-raised here; an ack while it is low is not ours.
        if (!bmem_req) begin
          breq_nxt  = 1'b1;
          bwe_nxt   = 1'b0;
          baddr_nxt = {req_tag, idx, 2'b00};
        end else if (bmem_ack) begin
          breq_nxt   = 1'b0;
          line_wdata = fill_word;
          line_we    = 1'b1;
          set_valid  = 1'b1;
          clr_dirty  = 1'b1;
          set_dirty  = req_write;
          rdata_nxt  = fill_word;
          ready_nxt  = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      bmem_req   <= 1'b0;
      bmem_we    <= 1'b0;
      bmem_addr  <= '0;
      bmem_wdata <= '0;
      line_valid <= '0;
      line_dirty <= '0;
    end else begin
      mem_ready  <= ready_nxt;
      mem_rdata  <= rdata_nxt;
      bmem_req   <= breq_nxt;
      bmem_we    <= bwe_nxt;
      bmem_addr  <= baddr_nxt;
      bmem_wdata <= bwdata_nxt;
      if (set_valid) line_valid[idx] <= 1'b1;
      if (clr_dirty) line_dirty[idx] <= 1'b0;
      if (set_dirty) line_dirty[idx] <= 1'b1;
    end
  end

  // Request latch and line storage need no reset; validity bits guard the arrays.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_word  <= mem_addr[8:2];
      req_wdata <= mem_wdata;
      req_wstrb <= mem_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && line_we) begin
      data_mem[idx] <= line_wdata;
      tag_mem[idx]  <= req_tag;
    end
  end

`ifdef PICO_L1_STATS_EN
  logic [15:0] hit_q;
  logic [15:0] miss_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_evt && (hit_q != 16'hFFFF))   hit_q  <= hit_q + 16'd1;
      if (miss_evt && (miss_q != 16'hFFFF)) miss_q <= miss_q + 16'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  logic unused_stats;
  assign unused_stats = hit_evt | miss_evt;
  assign hit_count    = '0;
  assign miss_count   = '0;
`endif

endmodule
